blake2_msg_packer: RTL

- Upstream feeder for the blake2 compression core.
- Accepts an arbitrary-length byte stream over a valid/ready handshake and cuts it into BB-byte blocks.
- Zero-pads the final block and drives the core's per-byte load interface: data_v, data_idx, data, block_first, block_last, ll.
- Paces itself on the core's ready indication, because the core itself cannot back-pressure.

---
 rtl/blake2_pkg.sv | 17 +
 rtl/blake2_msg_packer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/blake2_pkg.sv
// Shared definitions for the blake2 message packer: FSM state
// encoding and block-size / length-width defaults per variant.
package blake2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAD,
    S_WAIT_CORE
  } pack_state_t;

  localparam int BB_B   = 128;
  localparam int BB_S   = 64;
  localparam int LL_W_B = 128;
  localparam int LL_W_S = 64;

endpackage

// File: rtl/blake2_msg_packer.sv
// Byte-stream to blake2 block packer. Cuts the s_* stream into BB-byte
// blocks, zero-pads the last one and drives the core's per-byte load
// port (data_v/data_idx/data, block_first/block_last, ll), pacing on
// core_ready_i. Ports: clk, nreset (sync, active-low), s_valid_i,
// s_ready_o, s_data_i, s_last_i, s_empty_i, core_ready_i, data_v_o,
// data_idx_o, data_o, block_first_o, block_last_o, ll_o.
// Option BLAKE2_PACK_KEY_EN adds key_len_i: the first key_len_i beats
// form a zero-padded key block. A keyed empty message is sent as
// s_last_i on the final key byte.
module blake2_msg_packer
  import blake2_pkg::*;
#(
  parameter int BB = BB_B,
  parameter int LL_W = LL_W_B,
  localparam int BB_CLOG2 = $clog2(BB)
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [7:0]          s_data_i,
  input  logic                s_last_i,
  input  logic                s_empty_i,
`ifdef BLAKE2_PACK_KEY_EN
  input  logic [7:0]          key_len_i,
`endif
  input  logic                core_ready_i,
  output logic                data_v_o,
  output logic [BB_CLOG2-1:0] data_idx_o,
  output logic [7:0]          data_o,
  output logic                block_first_o,
  output logic                block_last_o,
  output logic [LL_W-1:0]     ll_o
);

  localparam logic [BB_CLOG2-1:0] IDX_MAX = BB_CLOG2'(BB - 1);
  localparam logic [BB_CLOG2-1:0] IDX_ONE = BB_CLOG2'(1);
  localparam logic [LL_W-1:0]     LL_MAX  = '1;
  localparam logic [LL_W-1:0]     LL_ONE  = LL_W'(1);
  localparam logic [LL_W-1:0]     LL_BB   = LL_W'(BB);

  pack_state_t         state_q, state_d;
  logic [BB_CLOG2-1:0] idx_q, idx_d;
  logic                fresh_q, fresh_d;
  logic                last_q, last_d;
  logic                seen_q, seen_d;
  logic                v_d, first_d, blast_d;
  logic [BB_CLOG2-1:0] didx_d;
  logic [7:0]          dat_d;
  logic [LL_W-1:0]     ll_d, ll_base, ll_inc;
  logic                xfer;
  logic                key_byte, key_end;

`ifdef BLAKE2_PACK_KEY_EN
  logic [7:0] key_q, key_d;
  assign key_byte = (key_q != 8'd0);
  assign key_end  = key_byte & ((key_q == 8'd1) | s_last_i);
`else
  assign key_byte = 1'b0;
  assign key_end  = 1'b0;
`endif

  assign s_ready_o = nreset & core_ready_i
                   & (state_q == S_DATA);
  assign xfer = s_valid_i & s_ready_o;

  // ll_o doubles as the running count; fresh_q marks that the next
  // accepted beat starts a new message so ll_o can hold until then.
  assign ll_base = fresh_q ? '0 : ll_o;
  assign ll_inc  = (ll_base == LL_MAX) ? ll_base
                 : ll_base + LL_ONE;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fresh_d = fresh_q;
    last_d  = last_q;
    seen_d  = seen_q;
    v_d     = 1'b0;
    first_d = block_first_o;
    blast_d = block_last_o;
    didx_d  = data_idx_o;
    dat_d   = data_o;
    ll_d    = ll_o;
`ifdef BLAKE2_PACK_KEY_EN
    key_d   = key_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        first_d = 1'b1;
        blast_d = 1'b0;
        last_d  = 1'b0;
        fresh_d = 1'b1;
        seen_d  = 1'b0;
        idx_d   = '0;
`ifdef BLAKE2_PACK_KEY_EN
        key_d   = key_len_i;
`endif
        state_d = S_DATA;
      end
      S_DATA: begin
        if (xfer) begin
          fresh_d = 1'b0;
          unique case (1'b1)
            s_empty_i: begin
              ll_d    = ll_base;
              blast_d = 1'b1;
              last_d  = 1'b1;
              state_d = S_PAD;
            end
            default: begin
              v_d    = 1'b1;
              didx_d = idx_q;
              dat_d  = s_data_i;
              idx_d  = idx_q + IDX_ONE;
              if (key_byte)
                ll_d = key_end ? LL_BB : ll_base;
              else
                ll_d = ll_inc;
`ifdef BLAKE2_PACK_KEY_EN
              if (key_byte)
                key_d = key_end ? 8'd0 : key_q - 8'd1;
`endif
              if (s_last_i) begin
                blast_d = 1'b1;
                last_d  = 1'b1;
              end
              if (idx_q == IDX_MAX)
                state_d = S_WAIT_CORE;
              else if (s_last_i | key_end)
                state_d = S_PAD;
            end
          endcase
        end
      end
      S_PAD: begin
        if (core_ready_i) begin
          v_d    = 1'b1;
          didx_d = idx_q;
          dat_d  = 8'h00;
          idx_d  = idx_q + IDX_ONE;
          if (idx_q == IDX_MAX)
            state_d = S_WAIT_CORE;
        end
      end
      S_WAIT_CORE: begin
        // The last byte is registered, so ready may still read high
        // the cycle after it; require a low then a high before moving.
        if (!core_ready_i) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          seen_d = 1'b0;
          if (last_q) begin
            state_d = S_IDLE;
          end else begin
            first_d = 1'b0;
            state_d = S_DATA;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      fresh_q       <= 1'b1;
      last_q        <= 1'b0;
      seen_q        <= 1'b0;
      data_v_o      <= 1'b0;
      data_idx_o    <= '0;
      data_o        <= 8'h00;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
      ll_o          <= '0;
`ifdef BLAKE2_PACK_KEY_EN
      key_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      fresh_q       <= fresh_d;
      last_q        <= last_d;
      seen_q        <= seen_d;
      data_v_o      <= v_d;
      data_idx_o    <= didx_d;
      data_o        <= dat_d;
      block_first_o <= first_d;
      block_last_o  <= blast_d;
      ll_o          <= ll_d;
`ifdef BLAKE2_PACK_KEY_EN
      key_q         <= key_d;
`endif
    end
  end

endmodule
